// File: rtl/var_state_ctrl.sv
// rtl/var_state_ctrl.sv - round-robin arbiter and clear sequencer in front of the var_state table
// Optional read-check-write conflict detection is enabled by defining VAR_STATE_CONFLICT_DETECT_EN.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 5
`endif

module var_state_ctrl #(
  parameter int NUM_REQ       = 3,
  parameter int MAX_VARS_BITS = `MAX_VARS_BITS,
  parameter int NUM_VARS      = 1 << MAX_VARS_BITS
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    clear_req,
  input  logic [NUM_REQ-1:0]                      req,
  input  logic [NUM_REQ-1:0]                      req_write,
  input  logic [NUM_REQ-1:0][MAX_VARS_BITS-1:0]   req_var,
  input  logic [NUM_REQ-1:0]                      req_val,
  input  logic [NUM_REQ-1:0]                      req_unassign,
  output logic [NUM_REQ-1:0]                      done,
  output logic                                    rsp_val,
  output logic                                    rsp_unassign,
  output logic                                    conflict,
  output logic                                    busy,
  output logic                                    vs_read,
  output logic                                    vs_write,
  output logic [MAX_VARS_BITS-1:0]                vs_var,
  output logic                                    vs_val,
  output logic                                    vs_unassign,
  input  logic                                    vs_val_out,
  input  logic                                    vs_unassign_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] CLEAR = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
`ifdef VAR_STATE_CONFLICT_DETECT_EN
  localparam logic [2:0] CHECK = 3'd5;
`endif

  localparam logic [MAX_VARS_BITS-1:0] LAST_IDX = MAX_VARS_BITS'(NUM_VARS - 1);

  logic [2:0]               state;
  logic [MAX_VARS_BITS-1:0] idx;
  logic [MAX_VARS_BITS-1:0] l_var;
  logic                     l_val;
  logic                     l_unassign;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            cur;
  logic [PW-1:0]            cand;
  logic [PW-1:0]            gnt_idx;
  logic [PW-1:0]            rr_next;
  logic                     gnt_found;
  logic                     finish;
`ifdef VAR_STATE_CONFLICT_DETECT_EN
  logic                     op_write;
`endif

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    rr_next = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      idx        <= '0;
      rr_ptr     <= '0;
      cur        <= '0;
      l_var      <= '0;
      l_val      <= 1'b0;
      l_unassign <= 1'b0;
`ifdef VAR_STATE_CONFLICT_DETECT_EN
      op_write   <= 1'b0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            idx   <= '0;
          end else if (gnt_found) begin
            cur        <= gnt_idx;
            rr_ptr     <= rr_next;
            l_var      <= req_var[gnt_idx];
            l_val      <= req_val[gnt_idx];
            l_unassign <= req_unassign[gnt_idx];
`ifdef VAR_STATE_CONFLICT_DETECT_EN
            op_write   <= req_write[gnt_idx];
            state      <= READ;
`else
            state      <= req_write[gnt_idx] ? WRITE : READ;
`endif
          end
        end
        READ: begin
`ifdef VAR_STATE_CONFLICT_DETECT_EN
          state <= op_write ? CHECK : RESP;
`else
          state <= RESP;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = !reset || (state != IDLE);

  // Everything facing the table is decoded from state so reset forces it quiet at once.
  always_comb begin
    finish       = 1'b0;
    done         = '0;
    rsp_val      = 1'b0;
    rsp_unassign = 1'b0;
    conflict     = 1'b0;
    vs_read      = 1'b0;
    vs_write     = 1'b0;
    vs_var       = '0;
    vs_val       = 1'b0;
    vs_unassign  = 1'b0;
    if (reset) begin
`ifdef VAR_STATE_CONFLICT_DETECT_EN
      finish = (state == RESP) || (state == WRITE) || (state == CHECK);
`else
      finish = (state == RESP) || (state == WRITE);
`endif
      if (finish) done = NUM_REQ'(1) << cur;
      case (state)
        CLEAR: begin
          vs_write    = 1'b1;
          vs_var      = idx;
          vs_unassign = 1'b1;
        end
        READ: begin
          vs_read = 1'b1;
          vs_var  = l_var;
        end
        RESP: begin
          rsp_val      = vs_val_out;
          rsp_unassign = vs_unassign_out;
        end
        WRITE: begin
          vs_write    = 1'b1;
          vs_var      = l_var;
          vs_val      = l_val;
          vs_unassign = l_unassign;
        end
`ifdef VAR_STATE_CONFLICT_DETECT_EN
        CHECK: begin
          // An assigned variable may not be flipped to the opposite value.
          conflict    = !vs_unassign_out && !l_unassign && (vs_val_out != l_val);
          vs_write    = !conflict;
          vs_var      = l_var;
          vs_val      = l_val;
          vs_unassign = l_unassign;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_var_state_ctrl.sv
// tb/tb_var_state_ctrl.sv - directed bench for var_state_ctrl with a cycle-level reference model
// Honours VAR_STATE_CONFLICT_DETECT_EN the same way the design does.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 5
`endif

module tb_var_state_ctrl;

  localparam int N  = 3;
  localparam int W  = `MAX_VARS_BITS;
  localparam int NV = 1 << W;
  localparam int VW = W + N + 8;
`ifdef VAR_STATE_CONFLICT_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear_req = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_write = '0;
  logic [N-1:0][W-1:0] req_var = '0;
  logic [N-1:0] req_val = '0;
  logic [N-1:0] req_unassign = '0;
  logic [N-1:0] done;
  logic rsp_val, rsp_unassign, conflict, busy;
  logic vs_read, vs_write, vs_val, vs_unassign;
  logic [W-1:0] vs_var;
  logic vs_val_out = 1'b0;
  logic vs_unassign_out = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int want [N] = '{default: 0};
  int got  [N] = '{default: 0};
  logic [N-1:0] dseen = '0;

  always #5 clock = ~clock;

  var_state_ctrl #(.NUM_REQ(N), .MAX_VARS_BITS(W)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req),
    .req(req), .req_write(req_write), .req_var(req_var),
    .req_val(req_val), .req_unassign(req_unassign),
    .done(done), .rsp_val(rsp_val), .rsp_unassign(rsp_unassign),
    .conflict(conflict), .busy(busy),
    .vs_read(vs_read), .vs_write(vs_write), .vs_var(vs_var),
    .vs_val(vs_val), .vs_unassign(vs_unassign),
    .vs_val_out(vs_val_out), .vs_unassign_out(vs_unassign_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Table behind the controller; starts with non-cleared contents.
  logic p_v [NV] = '{default: 1'b1};
  logic p_u [NV] = '{default: 1'b0};
  always @(posedge clock) begin
    if (vs_write) begin
      p_v[vs_var] <= vs_val;
      p_u[vs_var] <= vs_unassign;
    end
    if (vs_read) begin
      vs_val_out      <= p_v[vs_var];
      vs_unassign_out <= p_u[vs_var];
    end
  end

  // Requesters: keep req high while issued ops outnumber completions.
  always @(negedge clock) dseen <= done;
  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (dseen[i]) got[i]++;
      req[i] = (want[i] > got[i]);
    end
  end

  // Reference model: clear countdown, op latency countdown, round-robin pointer, table contents.
  int   m_clear = NV;
  logic m_op = 1'b0;
  int   m_lat = 0;
  int   m_req = 0;
  int   m_rr = 0;
  logic m_write = 1'b0;
  logic m_val = 1'b0;
  logic m_un = 1'b0;
  logic [W-1:0] m_var = '0;
  logic m_tv [NV] = '{default: 1'b0};
  logic m_tu [NV] = '{default: 1'b1};

  function automatic logic f_conflict();
    return DETECT && m_write && !m_tu[m_var] && !m_un && (m_tv[m_var] != m_val);
  endfunction

  always @(posedge clock or negedge reset) begin : model
    int sel;
    sel = -1;
    if (!reset) begin
      m_clear <= NV;
      m_op    <= 1'b0;
      m_rr    <= 0;
      for (int v = 0; v < NV; v++) begin
        m_tv[v] <= 1'b0;
        m_tu[v] <= 1'b1;
      end
    end else if (m_clear > 0) begin
      m_clear <= m_clear - 1;
    end else if (m_op) begin
      if (m_lat == 1) begin
        if (m_write && !f_conflict()) begin
          m_tv[m_var] <= m_val;
          m_tu[m_var] <= m_un;
        end
        m_op <= 1'b0;
      end else begin
        m_lat <= m_lat - 1;
      end
    end else if (clear_req) begin
      m_clear <= NV;
      for (int v = 0; v < NV; v++) begin
        m_tv[v] <= 1'b0;
        m_tu[v] <= 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (sel < 0 && req[(m_rr + k) % N]) sel = (m_rr + k) % N;
      if (sel >= 0) begin
        m_op    <= 1'b1;
        m_req   <= sel;
        m_write <= req_write[sel];
        m_var   <= req_var[sel];
        m_val   <= req_val[sel];
        m_un    <= req_unassign[sel];
        m_rr    <= (sel + 1) % N;
        m_lat   <= (req_write[sel] && !DETECT) ? 1 : 2;
      end
    end
  end

  always @(negedge clock) begin : cmp
    logic e_rd, e_wr, e_val, e_un, e_rv, e_ru, e_cf, e_busy, var_on, vu_on;
    logic [W-1:0] e_var;
    logic [N-1:0] e_done;
    logic [VW-1:0] act_v, exp_v, mask_v;
    e_rd = 0; e_wr = 0; e_val = 0; e_un = 0; e_rv = 0; e_ru = 0; e_cf = 0; e_busy = 0;
    var_on = 0; vu_on = 0; e_var = '0; e_done = '0;
    if (!reset) begin
      e_busy = 1;
    end else if (m_clear > 0) begin
      e_busy = 1; e_wr = 1; e_un = 1; var_on = 1; vu_on = 1;
      e_var = W'(NV - m_clear);
    end else if (m_op) begin
      e_busy = 1;
      if (m_lat == 2) begin
        e_rd = 1; e_var = m_var; var_on = 1;
      end else begin
        e_done[m_req] = 1'b1;
        if (!m_write) begin
          e_rv = m_tv[m_var];
          e_ru = m_tu[m_var];
        end else begin
          e_cf = f_conflict();
          e_wr = !e_cf;
          e_var = m_var; e_val = m_val; e_un = m_un;
          var_on = e_wr; vu_on = e_wr;
        end
      end
    end
    act_v  = {vs_read, vs_write, vs_var, vs_val, vs_unassign, done, rsp_val, rsp_unassign, conflict, busy};
    exp_v  = {e_rd, e_wr, e_var, e_val, e_un, e_done, e_rv, e_ru, e_cf, e_busy};
    mask_v = {2'b11, {W{var_on}}, vu_on, vu_on, {N{1'b1}}, 4'b1111};
    chk("cycle", 64'(act_v & mask_v), 64'(exp_v & mask_v));
  end

  task automatic run_op(input int i, input logic w, input int v, input logic val, input logic un,
                        output int lat, output logic o_val, output logic o_un, output logic o_cf);
    bit st;
    int n;
    st = 0; n = 0; lat = -1; o_val = 0; o_un = 0; o_cf = 0;
    @(posedge clock);
    #2;
    req_write[i] = w; req_var[i] = W'(v); req_val[i] = val; req_unassign[i] = un;
    want[i]++;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (req[i]) begin
        if (st) n++;
        st = 1;
      end
      if (done[i]) begin
        lat = n; o_val = rsp_val; o_un = rsp_unassign; o_cf = conflict;
        break;
      end
    end
    chk("op_completed", 64'(lat >= 0), 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin : main
    int lat, cyc, wr, ord, cnt;
    logic ov, ou, oc;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", busy, 1);
    chk("reset_outs", {vs_write, vs_read, done, conflict, rsp_val, rsp_unassign}, 0);

    @(posedge clock);
    #3 reset = 1'b1;
    cyc = 0; wr = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (!busy) break;
      cyc++;
      if (vs_write && !vs_val && vs_unassign) wr++;
    end
    chk("clear_cycles", cyc, 32);
    chk("clear_writes", wr, 32);

    // Three readers held continuously: completions rotate 0,1,2,0,1.
    @(posedge clock);
    #2;
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b0;
      req_var[i]   = W'(5);
    end
    want[0] += 2; want[1] += 2; want[2] += 1;
    ord = 0; cnt = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if (cnt == 0) begin
            chk("rd5_val", rsp_val, 0);
            chk("rd5_unassign", rsp_unassign, 1);
          end
          ord = ord * 10 + i + 1;
          cnt++;
        end
      end
      if (cnt == 5) break;
    end
    chk("rr_order", ord, 12312);

    run_op(0, 1'b1, 18, 1'b1, 1'b0, lat, ov, ou, oc);
    chk("wr18_latency", lat, DETECT ? 2 : 1);
    chk("wr18_conflict", oc, 0);
    run_op(1, 1'b0, 18, 1'b0, 1'b0, lat, ov, ou, oc);
    chk("rd18_latency", lat, 2);
    chk("rd18_val", ov, 1);
    chk("rd18_unassign", ou, 0);

    run_op(2, 1'b1, 18, 1'b0, 1'b0, lat, ov, ou, oc);
    chk("flip_conflict", oc, DETECT);
    run_op(0, 1'b0, 18, 1'b0, 1'b0, lat, ov, ou, oc);
    chk("flip_readback", ov, DETECT);

    // clear_req raised while a read sits in READ.
    @(posedge clock);
    #2;
    req_write[0] = 1'b0; req_var[0] = W'(18);
    want[0]++;
    @(posedge clock);
    @(posedge clock);
    #2 clear_req = 1'b1;
    lat = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (done[0]) begin
        lat = 1;
        break;
      end
    end
    chk("midclear_done", lat, 1);
    repeat (2) @(posedge clock);
    #2 clear_req = 1'b0;
    @(negedge clock);
    chk("midclear_busy", busy, 1);
    wait_idle();
    run_op(1, 1'b0, 18, 1'b0, 1'b0, lat, ov, ou, oc);
    chk("postclear_val", ov, 0);
    chk("postclear_unassign", ou, 1);

    // Reset while the write is in flight.
    @(posedge clock);
    #2;
    req_write[1] = 1'b1; req_var[1] = W'(18); req_val[1] = 1'b1; req_unassign[1] = 1'b0;
    want[1]++;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    want[1] = got[1];
    @(negedge clock);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 1);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    @(negedge clock);
    chk("restart_write", vs_write, 1);
    chk("restart_index", vs_var, 0);
    wait_idle();
    run_op(2, 1'b0, 18, 1'b0, 1'b0, lat, ov, ou, oc);
    chk("abort_unassign", ou, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1);
  end

endmodule

// File: doc/var_state_ctrl.md
# var_state_ctrl

Controller and arbiter in front of the `var_state` assignment table. It shares the table's single read/write port between `NUM_REQ` requesters (decider, implication engine, backtracker) using round-robin arbitration. It sequences a full-table clear after reset or on demand, and optionally performs read-check-write conflict detection on assignments. Sits between the solver engines and the `var_state` instance.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `NUM_VARS`, `1 << `MAX_VARS_BITS`, table entries walked by clear

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear_req`  in  1  request full-table clear (level, sampled in IDLE)
- `req`  in  NUM_REQ  per-requester request, held until `done[i]`
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_var`  in  NUM_REQ x `MAX_VARS_BITS`  variable index per requester
- `req_val`  in  NUM_REQ  value to write
- `req_unassign`  in  NUM_REQ  unassign flag to write
- `done`  out  NUM_REQ  one-hot completion pulse, one cycle
- `rsp_val`  out  1  read value, valid with `done` on reads, else 0
- `rsp_unassign`  out  1  read unassign flag, valid with `done` on reads, else 0
- `conflict`  out  1  write rejected, valid with `done` on writes, else 0
- `busy`  out  1  high in CLEAR or while an op is in flight
- `vs_read`, `vs_write`  out  1 each  to `var_state` `read`/`write`
- `vs_var`  out  `MAX_VARS_BITS`  to `var_state` `var_in`
- `vs_val`, `vs_unassign`  out  1 each  to `var_state` `val_in`/`unassign_in`
- `vs_val_out`, `vs_unassign_out`  in  1 each  from `var_state` outputs, valid the cycle after `vs_read`

## Operation
- States: CLEAR, IDLE, READ, RESP, WRITE, CHECK (CHECK only with the macro defined).
- CLEAR: index counter runs 0..NUM_VARS-1, one per cycle. Each cycle asserts `vs_write` with `vs_val`=0 and `vs_unassign`=1. After the last index, go to IDLE. `busy`=1 and no grants in this state.
- IDLE: `clear_req`=1 goes to CLEAR and has priority over `req`. Otherwise pick the first asserted `req[i]` at or after pointer `rr_ptr` (wrapping), then latch index, op, var, val and unassign. A read goes to READ. A write goes to WRITE, or to READ when `VAR_STATE_CONFLICT_DETECT_EN` is defined. `rr_ptr` becomes (i+1) mod NUM_REQ. No request leaves the FSM in IDLE with `busy`=0.
- READ: assert `vs_read` with the latched var, then go to RESP, or to CHECK for writes.
- RESP: `done[i]`=1 and `rsp_val`/`rsp_unassign` = `vs_val_out`/`vs_unassign_out`, then go to IDLE.
- WRITE: assert `vs_write` with the latched fields, set `done[i]`=1, then go to IDLE.
- CHECK: conflict when `vs_unassign_out`=0, the latched unassign=0 and `vs_val_out` != latched val. On conflict, `vs_write`=0 and `conflict`=1. Otherwise assert `vs_write`. Either way `done[i]`=1, then go to IDLE.
- Requesters hold all fields stable while `req` is high and drop `req` (or present a new op) the cycle after `done`.
- A `clear_req` arriving mid-op is honored only after the op completes.

## Timing
- Reset (`reset`=0, async): state=CLEAR, index=0, `rr_ptr`=0. While asserted, all `vs_*` outputs, `done`, `rsp_*` and `conflict` are 0, and `busy`=1. Clearing starts on the first edge after release.
- Clear takes NUM_VARS cycles; first grant is possible in cycle NUM_VARS after release.
- Read: accepted in cycle N, `vs_read` in N+1, `done` in N+2.
- Write: accepted in N, `vs_write` and `done` in N+1. With the macro: `vs_read` in N+1, check/write and `done` in N+2.
- Back-to-back ops leave one IDLE cycle between completions.
- `reset` mid-operation aborts the op with no `done` and restarts CLEAR.
- All `vs_*` outputs are driven combinationally from state and latched registers.

## Configuration
- `VAR_STATE_CONFLICT_DETECT_EN` defined: writes take the READ→CHECK path, and conflicting assignments are suppressed and flagged.
- Not defined: writes go IDLE→WRITE, `conflict` is tied 0, the CHECK state is absent, and writes always overwrite.

## Test plan
- Release reset -> `busy`=1 for NUM_VARS cycles with a `vs_write` per index (val 0, unassign 1); then read var 5 -> `rsp_val`=0, `rsp_unassign`=1.
- req0 writes var 18 (val 1, unassign 0), then req1 reads var 18 -> `done[0]` 1 cycle after accept (2 with macro); `done[1]` 2 cycles after accept with `rsp_val`=1, `rsp_unassign`=0.
- req0–req2 hold reads continuously from `rr_ptr`=0 -> `done` order 0,1,2,0,1.
- With macro: var 18 holds val 1; write var 18 val 0 unassign 0 -> `conflict`=1, no `vs_write`, later read returns 1. Without macro: read returns 0.
- `clear_req` pulsed while a read is in READ -> read completes with its `done`, then CLEAR runs; a read of var 18 afterwards returns `rsp_unassign`=1.
- `reset` asserted during WRITE -> no `done`, `busy`=1, CLEAR restarts at index 0 after release.
